// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED pattern generator: per-channel mode
//   encodings as seen on the ch_mode bus, and the burst FSM state codes.
//   No ports; imported by led_channel and led_pattern_gen.
// ----------------------------------------------------------------------------
package led_pkg;

    localparam int MODE_W = 2;

    // Encoding matches the 2-bit field of ch_mode for each channel.
    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } led_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } burst_state_e;

endpackage

// File: rtl/led_channel.sv
// ----------------------------------------------------------------------------
// led_channel
//   One independent LED channel. Holds a registered copy of its mode, a tick
//   counter for the half-period, the blink phase, and a small burst FSM.
//   The LED output is registered and derived only from internal state, so
//   there is no combinational path from any input to led.
//
// Ports
//   clk_128M  in   1        system clock
//   rst_n     in   1        asynchronous active-low reset
//   tick      in   1        shared 1-cycle timebase strobe
//   mode      in   2        00 OFF, 01 ON, 10 BLINK, 11 BURST
//   half_per  in   PER_W    half-period in ticks (0 behaves as 1)
//   burst_n   in   BURST_W  blinks per burst, sampled on trig (0 = 2^BURST_W)
//   trig      in   1        starts a burst when idle in BURST mode
//   led       out  1        LED drive, active high
//   busy      out  1        high while a burst is running
// ----------------------------------------------------------------------------
module led_channel
    import led_pkg::*;
#(
    parameter int PER_W   = 12,
    parameter int BURST_W = 4
) (
    input  logic               clk_128M,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [1:0]         mode,
    input  logic [PER_W-1:0]   half_per,
    input  logic [BURST_W-1:0] burst_n,
    input  logic               trig,
    output logic               led,
    output logic               busy
);

    // One extra bit so a burst_n of zero can load the full 2^BURST_W count.
    localparam int REM_W = BURST_W + 1;

    led_mode_e          mode_in;
    led_mode_e          mode_q,   mode_d;
    logic [PER_W-1:0]   cnt_q,    cnt_d;
    logic               phase_q,  phase_d;
    burst_state_e       state_q,  state_d;
    logic [REM_W-1:0]   remain_q, remain_d;
    logic               led_q,    led_d;

    logic [PER_W-1:0]   hp_last;
    logic               wrap;
    logic [REM_W-1:0]   burst_load;

    always_comb begin
        mode_in    = led_mode_e'(mode);
        // Terminal count is hp-1 with hp clamped to at least 1.
        hp_last    = (half_per == '0) ? '0 : half_per - PER_W'(1);
        // ">=" rather than "==" so lowering half_per below the current
        // count wraps on the next tick instead of running to overflow.
        wrap       = (cnt_q >= hp_last);
        burst_load = (burst_n == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, burst_n};
    end

    // Next-state logic
    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        state_d  = state_q;
        remain_d = remain_q;

        if (mode_in != mode_q) begin
            // A mode change restarts the channel; any trig in this cycle is
            // deliberately dropped.
            mode_d   = mode_in;
            cnt_d    = '0;
            phase_d  = (mode_in == MODE_BLINK);
            state_d  = ST_IDLE;
            remain_d = '0;
        end else begin
            unique case (mode_q)
                MODE_BLINK: begin
                    if (tick) begin
                        if (wrap) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + PER_W'(1);
                        end
                    end
                end
                MODE_BURST: begin
                    if (state_q == ST_IDLE) begin
                        if (trig) begin
                            state_d  = ST_RUN;
                            remain_d = burst_load;
                            cnt_d    = '0;
                            phase_d  = 1'b1;
                        end
                    end else if (tick) begin
                        if (wrap) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                            // A blink is counted on its falling (1->0) toggle.
                            if (phase_q) begin
                                if (remain_q == REM_W'(1)) begin
                                    state_d  = ST_IDLE;
                                    remain_d = '0;
                                end else begin
                                    remain_d = remain_q - REM_W'(1);
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + PER_W'(1);
                        end
                    end
                end
                default: begin
                    // OFF and ON hold all timing state.
                end
            endcase
        end
    end

    // Output decode from the registered mode and current state
    always_comb begin
        led_d = 1'b0;
        unique case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase_q;
            MODE_BURST: led_d = (state_q == ST_RUN) && phase_q;
        endcase
    end

    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            state_q  <= ST_IDLE;
            remain_q <= '0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            state_q  <= state_d;
            remain_q <= remain_d;
            led_q    <= led_d;
        end
    end

    assign led  = led_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: rtl/led_pattern_gen.sv
// ----------------------------------------------------------------------------
// led_pattern_gen
//   Multi-channel LED driver. A single prescaler divides clk_128M down to a
//   TICK_HZ strobe that is shared by N_CH independent led_channel instances,
//   each running OFF / ON / BLINK / BURST.
//
// Ports
//   clk_128M     in   1              system clock
//   rst_n        in   1              async assert, sync deassert, active low
//   ch_mode      in   2*N_CH         per channel [2c+1:2c] mode
//   ch_half_per  in   PER_W*N_CH     per channel half-period in ticks
//   ch_burst_n   in   BURST_W*N_CH   per channel blinks per burst
//   ch_trig      in   N_CH           per channel burst trigger pulse
//   ch_busy      out  N_CH           per channel burst in progress
//   led          out  N_CH           LED drive, active high
//   tick         out  1              1-cycle strobe every CLK_HZ/TICK_HZ clocks
// ----------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ  = 128_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int PER_W   = 12,
    parameter int BURST_W = 4
) (
    input  logic                     clk_128M,
    input  logic                     rst_n,
    input  logic [2*N_CH-1:0]        ch_mode,
    input  logic [PER_W*N_CH-1:0]    ch_half_per,
    input  logic [BURST_W*N_CH-1:0]  ch_burst_n,
    input  logic [N_CH-1:0]          ch_trig,
    output logic [N_CH-1:0]          ch_busy,
    output logic [N_CH-1:0]          led,
    output logic                     tick
);

    localparam int PRE   = CLK_HZ / TICK_HZ;
    // Keep at least one bit so PRE==1 (tick every cycle) still elaborates.
    localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q,    tick_d;
    logic             pre_end;

    // Prescaler: tick is registered, so it appears the cycle after the
    // terminal count and the first one lands PRE cycles after reset.
    always_comb begin
        pre_end   = (pre_cnt_q == PRE_W'(PRE - 1));
        pre_cnt_d = pre_end ? '0 : pre_cnt_q + PRE_W'(1);
        tick_d    = pre_end;
    end

    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        led_channel #(
            .PER_W   (PER_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk_128M (clk_128M),
            .rst_n    (rst_n),
            .tick     (tick_q),
            .mode     (ch_mode[2*c +: 2]),
            .half_per (ch_half_per[PER_W*c +: PER_W]),
            .burst_n  (ch_burst_n[BURST_W*c +: BURST_W]),
            .trig     (ch_trig[c]),
            .led      (led[c]),
            .busy     (ch_busy[c])
        );
    end

endmodule
